// File: rtl/char_text_buffer_pkg.sv
// Shared definitions for the character text buffer.
// Holds panel/cell geometry, the control codes interpreted on the write
// stream, the FSM state encoding and the cell address helper.
package char_text_buffer_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 480;
  localparam int CELL_W   = 8;
  localparam int CELL_H   = 16;
  localparam int COLS     = H_ACTIVE / CELL_W;   // 100
  localparam int ROWS     = V_ACTIVE / CELL_H;   // 30
  localparam int CELLS    = COLS * ROWS;         // 3000
  localparam int ADDR_W   = $clog2(CELLS);       // 12

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [6:0]        X_LAST    = 7'(COLS - 1);
  localparam logic [4:0]        Y_LAST    = 5'(ROWS - 1);

  localparam logic [6:0] BLANK_CHAR = 7'h20;
  localparam logic [6:0] CR         = 7'h0D;
  localparam logic [6:0] LF         = 7'h0A;
  localparam logic [6:0] BS         = 7'h08;
  localparam logic [6:0] FF         = 7'h0C;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Linear cell index row*COLS + col, kept in the full address width.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] row,
                                                  input logic [7:0] col);
    return ({{(ADDR_W-6){1'b0}}, row} * ADDR_W'(COLS))
           + {{(ADDR_W-8){1'b0}}, col};
  endfunction

endpackage

// File: rtl/char_text_buffer_if.sv
// ASCII write stream with valid/ready handshake.
//   In_data  : 7-bit ASCII code
//   In_valid : In_data is valid
//   In_ready : buffer accepts In_data this cycle
// master = character source, slave = char_text_buffer.
interface char_text_buffer_if;
  logic [6:0] In_data;
  logic       In_valid;
  logic       In_ready;

  modport master (output In_data, output In_valid, input In_ready);
  modport slave  (input In_data, input In_valid, output In_ready);
endinterface

// File: rtl/char_text_buffer_text_ram.sv
// CELLS x 7 simple dual-port text RAM: one write port, one registered
// read port, read-first on address collision. Not reset.
//   clk   : clock
//   we    : write enable, waddr/wdata : write address/data
//   re    : read enable, raddr : read address, rdata : registered data
module char_text_buffer_text_ram
  import char_text_buffer_pkg::*;
#(
  parameter int DEPTH = CELLS,
  parameter int AW    = ADDR_W,
  parameter int DW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port and read-first registered read port share one clocked block.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/char_text_buffer.sv
// Screen text memory feeding the glyph ROM of an 800x480 panel.
//   CLK, RST_n          : clock, async active-low reset
//   wr (slave)          : ASCII write stream In_data/In_valid/In_ready
//   Clear               : request to blank the screen
//   Busy                : clear sweep in progress
//   Cursor_x/Cursor_y   : write cursor
//   Fila/Columna        : current pixel from the sync generator
//   Char_code           : character at that pixel (1-cycle latency)
//   Glyph_row/Glyph_col : in-cell pixel position, aligned with Char_code
module char_text_buffer
  import char_text_buffer_pkg::*;
(
  input  logic                CLK,
  input  logic                RST_n,
  char_text_buffer_if.slave   wr,
  input  logic [9:0]          Fila,
  input  logic [10:0]         Columna,
  input  logic                Clear,
  output logic                Busy,
  output logic [6:0]          Cursor_x,
  output logic [4:0]          Cursor_y,
  output logic [6:0]          Char_code,
  output logic [3:0]          Glyph_row,
  output logic [2:0]          Glyph_col
);

  state_t              state_r, state_next_s;
  logic [ADDR_W-1:0]   idx_r, idx_next_s;
  logic [6:0]          cur_x_r, x_next_s, adv_x_s, ret_x_s;
  logic [4:0]          cur_y_r, y_next_s, adv_y_s, ret_y_s, y_inc_s;
  logic                busy_r, ready_r;
  logic                xfer_s, printable_s;
  logic                we_s;
  logic [ADDR_W-1:0]   waddr_s;
  logic [6:0]          wdata_s;
  logic                in_area_s, in_area_r;
  logic [ADDR_W-1:0]   raddr_s;
  logic [6:0]          ram_rdata_s;
  logic [3:0]          glyph_row_r;
  logic [2:0]          glyph_col_r;

  assign xfer_s      = wr.In_valid & ready_r;
  assign printable_s = (wr.In_data >= 7'h20) && (wr.In_data <= 7'h7E);

  // Cursor neighbours: next cell (advance) and previous cell (retreat).
  always_comb begin
    y_inc_s = (cur_y_r == Y_LAST) ? 5'd0 : cur_y_r + 5'd1;
    if (cur_x_r == X_LAST) begin
      adv_x_s = 7'd0;
      adv_y_s = y_inc_s;
    end else begin
      adv_x_s = cur_x_r + 7'd1;
      adv_y_s = cur_y_r;
    end
    if (cur_x_r != 7'd0) begin
      ret_x_s = cur_x_r - 7'd1;
      ret_y_s = cur_y_r;
    end else if (cur_y_r != 5'd0) begin
      ret_x_s = X_LAST;
      ret_y_s = cur_y_r - 5'd1;
    end else begin
      // Home position: the cursor holds, the cell still gets blanked.
      ret_x_s = 7'd0;
      ret_y_s = 5'd0;
    end
  end

  // Next-state, cursor and RAM write-port decode.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    x_next_s     = cur_x_r;
    y_next_s     = cur_y_r;
    we_s         = 1'b0;
    waddr_s      = idx_r;
    wdata_s      = BLANK_CHAR;
    case (state_r)
      ST_CLEAR: begin
        // Clear requests are ignored here; the sweep is never restarted.
        we_s = 1'b1;
        if (idx_r == LAST_CELL) begin
          state_next_s = ST_IDLE;
          idx_next_s   = {ADDR_W{1'b0}};
          x_next_s     = 7'd0;
          y_next_s     = 5'd0;
        end else begin
          idx_next_s = idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_IDLE: begin
        if (Clear) begin
          // Clear wins over a simultaneous transfer; the character is dropped.
          state_next_s = ST_CLEAR;
          idx_next_s   = {ADDR_W{1'b0}};
        end else if (xfer_s) begin
          case (wr.In_data)
            CR: x_next_s = 7'd0;
            LF: begin
              x_next_s = 7'd0;
              y_next_s = y_inc_s;
            end
            BS: begin
              x_next_s = ret_x_s;
              y_next_s = ret_y_s;
              we_s     = 1'b1;
              waddr_s  = cell_addr({1'b0, ret_y_s}, {1'b0, ret_x_s});
              wdata_s  = BLANK_CHAR;
            end
            FF: begin
              state_next_s = ST_CLEAR;
              idx_next_s   = {ADDR_W{1'b0}};
            end
            default: begin
              if (printable_s) begin
                we_s     = 1'b1;
                waddr_s  = cell_addr({1'b0, cur_y_r}, {1'b0, cur_x_r});
                wdata_s  = wr.In_data;
                x_next_s = adv_x_s;
                y_next_s = adv_y_s;
              end else begin
                // Unsupported code: consumed without effect.
                we_s = 1'b0;
              end
            end
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_CLEAR;
        idx_next_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Control state, cursor and handshake flags.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r <= ST_CLEAR;
      idx_r   <= {ADDR_W{1'b0}};
      cur_x_r <= 7'd0;
      cur_y_r <= 5'd0;
      busy_r  <= 1'b1;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
      cur_x_r <= x_next_s;
      cur_y_r <= y_next_s;
      busy_r  <= (state_next_s == ST_CLEAR);
      ready_r <= (state_next_s == ST_IDLE);
    end
  end

  // Pixel-to-cell mapping; outside the active area the RAM is not accessed.
  always_comb begin
    in_area_s = (Fila < 10'(V_ACTIVE)) && (Columna < 11'(H_ACTIVE));
    if (in_area_s) begin
      raddr_s = cell_addr(Fila[9:4], Columna[10:3]);
    end else begin
      raddr_s = {ADDR_W{1'b0}};
    end
  end

  // Glyph position and area flag registered alongside the RAM read.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      in_area_r   <= 1'b0;
      glyph_row_r <= 4'd0;
      glyph_col_r <= 3'd0;
    end else begin
      in_area_r   <= in_area_s;
      glyph_row_r <= Fila[3:0];
      glyph_col_r <= Columna[2:0];
    end
  end

  char_text_buffer_text_ram u_text_ram (
    .clk   (CLK),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .re    (in_area_s),
    .raddr (raddr_s),
    .rdata (ram_rdata_s)
  );

  assign wr.In_ready = ready_r;
  assign Busy        = busy_r;
  assign Cursor_x    = cur_x_r;
  assign Cursor_y    = cur_y_r;
  // The RAM data register is not reset, so the area flag selects blank.
  assign Char_code   = in_area_r ? ram_rdata_s : BLANK_CHAR;
  assign Glyph_row   = glyph_row_r;
  assign Glyph_col   = glyph_col_r;

endmodule

// File: tb/tb_char_text_buffer.sv
module tb_char_text_buffer;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [9:0]  Fila;
  logic [10:0] Columna;
  logic        Clear;
  logic        Busy;
  logic [6:0]  Cursor_x;
  logic [4:0]  Cursor_y;
  logic [6:0]  Char_code;
  logic [3:0]  Glyph_row;
  logic [2:0]  Glyph_col;
  int          errors = 0;
  int          checks = 0;
  int          cnt;
  int          bad;

  char_text_buffer_if wr_if ();

  char_text_buffer dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .wr        (wr_if),
    .Fila      (Fila),
    .Columna   (Columna),
    .Clear     (Clear),
    .Busy      (Busy),
    .Cursor_x  (Cursor_x),
    .Cursor_y  (Cursor_y),
    .Char_code (Char_code),
    .Glyph_row (Glyph_row),
    .Glyph_col (Glyph_col)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge with In_ready high: one transfer at the next posedge.
  task automatic send(input logic [6:0] ch);
    wr_if.In_data  = ch;
    wr_if.In_valid = 1'b1;
    @(negedge CLK);
    wr_if.In_valid = 1'b0;
  endtask

  task automatic look(input int row, input int col);
    Fila    = 10'(row);
    Columna = 11'(col);
    @(negedge CLK);
  endtask

  // Counts cycles until Busy drops (bounded); optional Clear pulse at pulse_at.
  task automatic wait_sweep(input int pulse_at, output int n);
    n = 0;
    while (Busy === 1'b1 && n < 5000) begin
      Clear = (n == pulse_at);
      @(negedge CLK);
      n++;
    end
    Clear = 1'b0;
  endtask

  initial begin
    RST_n = 1'b0; Clear = 1'b0; Fila = 10'd0; Columna = 11'd0;
    wr_if.In_valid = 1'b0; wr_if.In_data = 7'h00;
    repeat (3) @(negedge CLK);
    chk("rst_busy", Busy, 1'b1);
    chk("rst_ready", wr_if.In_ready, 1'b0);
    chk("rst_char", Char_code, 7'h20);
    chk("rst_grow", Glyph_row, 4'd0);
    chk("rst_gcol", Glyph_col, 3'd0);
    RST_n = 1'b1;
    wait_sweep(-1, cnt);
    chk("init_sweep_len", cnt, 3000);
    chk("init_ready", wr_if.In_ready, 1'b1);
    chk("init_cursor", {Cursor_y, Cursor_x}, {5'd0, 7'd0});

    bad = 0;
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 100; c++) begin
        look(r * 16, c * 8);
        if (Char_code !== 7'h20) bad++;
      end
    end
    chk("all_blank", bad, 0);

    send(7'h41); send(7'h42);
    chk("ab_cursor", {Cursor_y, Cursor_x}, {5'd0, 7'd2});
    look(5, 9);
    chk("ab_char", Char_code, 7'h42);
    chk("ab_grow", Glyph_row, 4'd5);
    chk("ab_gcol", Glyph_col, 3'd1);
    look(0, 7);
    chk("a_char", Char_code, 7'h41);

    repeat (29) send(7'h0A);
    repeat (99) send(7'h2E);
    chk("corner_cursor", {Cursor_y, Cursor_x}, {5'd29, 7'd99});
    send(7'h5A);
    chk("wrap_cursor", {Cursor_y, Cursor_x}, {5'd0, 7'd0});
    look(479, 799);
    chk("cell2999", Char_code, 7'h5A);
    chk("cell2999_grow", Glyph_row, 4'd15);

    repeat (29) send(7'h0A);
    send(7'h78); send(7'h79); send(7'h7A);
    chk("x3y29", {Cursor_y, Cursor_x}, {5'd29, 7'd3});
    send(7'h0A);
    chk("lf_wrap", {Cursor_y, Cursor_x}, {5'd0, 7'd0});

    send(7'h61); send(7'h62); send(7'h0D);
    chk("cr_cursor", {Cursor_y, Cursor_x}, {5'd0, 7'd0});
    look(0, 16);
    chk("cr_nowrite", Char_code, 7'h20);

    send(7'h0A);
    send(7'h08);
    chk("bs_row_back", {Cursor_y, Cursor_x}, {5'd0, 7'd99});
    send(7'h4B);
    look(0, 792);
    chk("cell99_k", Char_code, 7'h4B);
    send(7'h08);
    look(0, 792);
    chk("cell99_bs", Char_code, 7'h20);

    send(7'h0D); send(7'h4D); send(7'h08); send(7'h08);
    chk("bs_home", {Cursor_y, Cursor_x}, {5'd0, 7'd0});
    send(7'h01); send(7'h7F);
    chk("ignored_cursor", {Cursor_y, Cursor_x}, {5'd0, 7'd0});
    look(0, 0);
    chk("bs_home_blank", Char_code, 7'h20);

    // Read-first collision on cell 0.
    Fila = 10'd0; Columna = 11'd0;
    wr_if.In_data = 7'h52; wr_if.In_valid = 1'b1;
    @(negedge CLK);
    wr_if.In_valid = 1'b0;
    chk("rf_old", Char_code, 7'h20);
    @(negedge CLK);
    chk("rf_new", Char_code, 7'h52);

    // Clear and 'Q' together; Clear again mid-sweep.
    Clear = 1'b1; wr_if.In_data = 7'h51; wr_if.In_valid = 1'b1;
    @(negedge CLK);
    Clear = 1'b0; wr_if.In_valid = 1'b0;
    chk("clrq_busy", Busy, 1'b1);
    chk("clrq_ready", wr_if.In_ready, 1'b0);
    chk("clrq_noadv", Cursor_x, 7'd1);
    wait_sweep(100, cnt);
    chk("clr_sweep_len", cnt, 3000);
    chk("clr_cursor", {Cursor_y, Cursor_x}, {5'd0, 7'd0});
    look(0, 0);
    chk("clr_cell0", Char_code, 7'h20);

    send(7'h0A); send(7'h57);
    look(16, 0);
    chk("w_cell100", Char_code, 7'h57);
    look(0, 800);
    chk("oob_col800", Char_code, 7'h20);
    look(100, 850);
    chk("oob_850_100", Char_code, 7'h20);
    look(480, 0);
    chk("oob_row480", Char_code, 7'h20);

    // Form feed, then reset part-way through its sweep.
    send(7'h0C);
    chk("ff_busy", Busy, 1'b1);
    Fila = 10'd21; Columna = 11'd3;
    repeat (49) @(negedge CLK);
    chk("pre_rst_char", Char_code, 7'h57);
    chk("pre_rst_gcol", Glyph_col, 3'd3);
    RST_n = 1'b0;
    #1;
    chk("mid_rst_char", Char_code, 7'h20);
    chk("mid_rst_grow", Glyph_row, 4'd0);
    chk("mid_rst_cursor", {Cursor_y, Cursor_x}, {5'd0, 7'd0});
    chk("mid_rst_ready", wr_if.In_ready, 1'b0);
    @(negedge CLK);
    RST_n = 1'b1;
    wait_sweep(-1, cnt);
    chk("rst_sweep_len", cnt, 3000);
    look(16, 0);
    chk("rst_cell100", Char_code, 7'h20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
